// File: rtl/router_port_monitor.sv
// Per-terminal router output monitor: starvation, pop-without-pending and misroute detection,
// sticky flags, saturating error count and per-terminal packet counters.
// Optional: define ROUTER_MON_BCAST_EN to accept an all-ones destination at every terminal.
module router_port_monitor #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLUMS  = 4,
  parameter int unsigned PCK_SZ  = 40,
  parameter int unsigned DST_MSB = 39,
  parameter int unsigned DST_LSB = 34,
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned N_TERMS = 2 * ROWS + 2 * COLUMS,
  localparam int unsigned SEL_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PCK_SZ-1:0]   data_out [N_TERMS],
  input  logic [N_TERMS-1:0]  pndng,
  input  logic [N_TERMS-1:0]  pop,
  input  logic                clr,
  input  logic [SEL_W-1:0]    cnt_sel,
  output logic [N_TERMS-1:0]  timeout_err,
  output logic [N_TERMS-1:0]  dst_err,
  output logic [N_TERMS-1:0]  pop_err,
  output logic                err_any,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    pkt_cnt_rd
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DST_W  = DST_MSB - DST_LSB + 1;
  localparam int unsigned EV_W   = $clog2(3 * N_TERMS + 1);
  localparam int unsigned SUM_W  = CNT_W + EV_W;

  logic [WAIT_W-1:0]  r_wait      [N_TERMS];
  logic [CNT_W-1:0]   r_pkt_cnt   [N_TERMS];
  logic [N_TERMS-1:0] r_timeout_err, r_dst_err, r_pop_err;
  logic               r_err_any;
  logic [CNT_W-1:0]   r_err_cnt, r_pkt_cnt_rd;

  logic [N_TERMS-1:0] w_accept, w_stall, w_to_ev, w_pop_ev, w_dst_ev;
  logic [EV_W-1:0]    w_ev_num;
  logic [SUM_W-1:0]   w_err_sum;
  logic [CNT_W-1:0]   w_err_cnt_d;
  logic [CNT_W-1:0]   w_pkt_sel;

  for (genvar g = 0; g < N_TERMS; g++) begin : g_term
    logic [DST_W-1:0] w_dst;
    logic             w_bcast;
    logic             w_mismatch;
    logic             w_unused_bits;

    assign w_dst = data_out[g][DST_MSB:DST_LSB];
`ifdef ROUTER_MON_BCAST_EN
    assign w_bcast = &w_dst;
`else
    assign w_bcast = 1'b0;
`endif
    // Compare at 32 bits so a terminal index wider than the field is never aliased.
    assign w_mismatch    = (32'(w_dst) != 32'(g));
    assign w_unused_bits = ^data_out[g];

    assign w_accept[g] = pndng[g] & pop[g];
    assign w_stall[g]  = pndng[g] & ~pop[g];
    assign w_to_ev[g]  = w_stall[g] & (r_wait[g] == WAIT_W'(TIMEOUT - 1));
    assign w_pop_ev[g] = pop[g] & ~pndng[g];
    assign w_dst_ev[g] = w_accept[g] & w_mismatch & ~w_bcast;
  end

  always_comb begin
    w_ev_num = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      w_ev_num = w_ev_num + EV_W'(w_to_ev[i]) + EV_W'(w_pop_ev[i]) + EV_W'(w_dst_ev[i]);
    end
  end

  assign w_err_sum   = SUM_W'(r_err_cnt) + SUM_W'(w_ev_num);
  assign w_err_cnt_d = (w_err_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                          : w_err_sum[CNT_W-1:0];

  always_comb begin
    w_pkt_sel = '0;
    if (32'(cnt_sel) < N_TERMS) begin
      w_pkt_sel = r_pkt_cnt[cnt_sel];
    end
  end

  // Wait counters saturate at TIMEOUT so a stall episode raises at most one timeout event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_TERMS; i++) begin
        r_wait[i]    <= '0;
        r_pkt_cnt[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < N_TERMS; i++) begin
        r_wait[i]    <= '0;
        r_pkt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_TERMS; i++) begin
        if (w_stall[i]) begin
          if (r_wait[i] != WAIT_W'(TIMEOUT)) begin
            r_wait[i] <= r_wait[i] + 1'b1;
          end
        end else begin
          r_wait[i] <= '0;
        end
        if (w_accept[i]) begin
          r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= '0;
      r_dst_err     <= '0;
      r_pop_err     <= '0;
      r_err_any     <= 1'b0;
      r_err_cnt     <= '0;
      r_pkt_cnt_rd  <= '0;
    end else if (clr) begin
      r_timeout_err <= '0;
      r_dst_err     <= '0;
      r_pop_err     <= '0;
      r_err_any     <= 1'b0;
      r_err_cnt     <= '0;
      r_pkt_cnt_rd  <= '0;
    end else begin
      r_timeout_err <= r_timeout_err | w_to_ev;
      r_dst_err     <= r_dst_err | w_dst_ev;
      r_pop_err     <= r_pop_err | w_pop_ev;
      r_err_any     <= |{r_timeout_err, r_dst_err, r_pop_err};
      r_err_cnt     <= w_err_cnt_d;
      r_pkt_cnt_rd  <= w_pkt_sel;
    end
  end

  assign timeout_err = r_timeout_err;
  assign dst_err     = r_dst_err;
  assign pop_err     = r_pop_err;
  assign err_any     = r_err_any;
  assign err_cnt     = r_err_cnt;
  assign pkt_cnt_rd  = r_pkt_cnt_rd;

endmodule

// File: tb/tb_router_port_monitor.sv
// Scoreboard bench for router_port_monitor (TIMEOUT=8, CNT_W=4, 16 terminals).
module tb_router_port_monitor;

  localparam int NT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [39:0]   data_out [NT];
  logic [NT-1:0] pndng, pop;
  logic          clr;
  logic [3:0]    cnt_sel;
  logic [NT-1:0] timeout_err, dst_err, pop_err;
  logic          err_any;
  logic [3:0]    err_cnt, pkt_cnt_rd;

  always #5 clk = ~clk;

  router_port_monitor #(
    .ROWS(4), .COLUMS(4), .PCK_SZ(40), .DST_MSB(39), .DST_LSB(34), .TIMEOUT(8), .CNT_W(4)
  ) u_dut (
    .clk(clk), .reset(reset), .data_out(data_out), .pndng(pndng), .pop(pop), .clr(clr),
    .cnt_sel(cnt_sel), .timeout_err(timeout_err), .dst_err(dst_err), .pop_err(pop_err),
    .err_any(err_any), .err_cnt(err_cnt), .pkt_cnt_rd(pkt_cnt_rd)
  );

  typedef struct packed {
    logic [31:0] at;
    logic [15:0] to;
    logic [15:0] de;
    logic [15:0] pe;
    logic        any;
    logic [3:0]  ec;
    logic [3:0]  pr;
  } exp_t;

  exp_t        q[$];
  string       qn[$];
  exp_t        m_e;
  string       m_nm;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_lost = 0;

`ifdef ROUTER_MON_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].at <= cyc) begin
      m_e  = q.pop_front();
      m_nm = qn.pop_front();
      n_checks++;
      if ({timeout_err, dst_err, pop_err, err_any, err_cnt, pkt_cnt_rd} ===
          {m_e.to, m_e.de, m_e.pe, m_e.any, m_e.ec, m_e.pr}) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got to=%h de=%h pe=%h any=%b ec=%0d rd=%0d, want to=%h de=%h pe=%h any=%b ec=%0d rd=%0d",
                 m_nm, timeout_err, dst_err, pop_err, err_any, err_cnt, pkt_cnt_rd,
                 m_e.to, m_e.de, m_e.pe, m_e.any, m_e.ec, m_e.pr);
      end
    end
  end

  task automatic expect_now(input string name, input logic [15:0] to, input logic [15:0] de,
                            input logic [15:0] pe, input logic any, input logic [3:0] ec,
                            input logic [3:0] pr);
    exp_t e;
    e.at = cyc; e.to = to; e.de = de; e.pe = pe; e.any = any; e.ec = ec; e.pr = pr;
    q.push_back(e);
    qn.push_back(name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dst(input int t, input logic [5:0] d);
    data_out[t] = {d, 34'h2_A5A5_0F0F};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; pndng = '0; pop = '0; cnt_sel = '0;
    for (int i = 0; i < NT; i++) set_dst(i, 6'(i));
    tick(); tick();
    expect_now("reset_state", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Starvation on terminal 3
    pndng[3] = 1'b1;
    repeat (7) tick();
    expect_now("stall_7_edges", 0, 0, 0, 0, 0, 0);
    tick();
    expect_now("timeout_fire", 16'h0008, 0, 0, 0, 1, 0);
    tick();
    expect_now("err_any_lag", 16'h0008, 0, 0, 1, 1, 0);
    repeat (19) tick();
    expect_now("timeout_once", 16'h0008, 0, 0, 1, 1, 0);
    pndng = '0; clr = 1'b1; tick(); clr = 1'b0;
    expect_now("clr_all", 0, 0, 0, 0, 0, 0);

    // Accept on the TIMEOUT-th edge at terminal 5
    pndng[5] = 1'b1;
    repeat (7) tick();
    pop[5] = 1'b1; tick();
    pndng = '0; pop = '0; cnt_sel = 4'd5;
    expect_now("late_accept_rd_lag", 0, 0, 0, 0, 0, 0);
    tick();
    expect_now("pkt_cnt_t5", 0, 0, 0, 0, 0, 1);

    // Misroute at terminal 2 and pop error at terminal 7 on the same edge
    set_dst(2, 6'd9); pndng[2] = 1'b1; pop[2] = 1'b1; pop[7] = 1'b1; tick();
    expect_now("dst_pop_same_edge", 0, 16'h0004, 16'h0080, 0, 2, 1);
    pndng = '0; pop = '0; cnt_sel = 4'd2; tick();
    expect_now("misroute_counted", 0, 16'h0004, 16'h0080, 1, 2, 1);

    // Clear beats a same-edge misroute at terminal 0
    set_dst(0, 6'd3); pndng[0] = 1'b1; pop[0] = 1'b1; clr = 1'b1; cnt_sel = 4'd0; tick();
    expect_now("clr_wins", 0, 0, 0, 0, 0, 0);
    pndng = '0; pop = '0; clr = 1'b0; tick();
    expect_now("pkt0_cleared", 0, 0, 0, 0, 0, 0);
    cnt_sel = 4'd2; tick();
    expect_now("pkt2_cleared", 0, 0, 0, 0, 0, 0);

    // All-ones destination at terminal 4
    set_dst(4, 6'h3F); pndng[4] = 1'b1; pop[4] = 1'b1; tick();
    expect_now("bcast_dst", 0, BCAST ? 16'h0000 : 16'h0010, 0, 0, BCAST ? 4'd0 : 4'd1, 0);
    pndng = '0; pop = '0; cnt_sel = 4'd4; tick();
    expect_now("bcast_cnt", 0, BCAST ? 16'h0000 : 16'h0010, 0, !BCAST,
               BCAST ? 4'd0 : 4'd1, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    expect_now("clr_again", 0, 0, 0, 0, 0, 0);

    // Error counter saturation, including a 2-event edge crossing the limit
    pop[7] = 1'b1;
    repeat (14) tick();
    expect_now("err_cnt_14", 0, 0, 16'h0080, 1, 14, 0);
    pop[6] = 1'b1; tick();
    expect_now("err_cnt_sat", 0, 0, 16'h00C0, 1, 15, 0);
    pop[6] = 1'b0;
    repeat (5) tick();
    expect_now("err_cnt_hold", 0, 0, 16'h00C0, 1, 15, 0);

    // Asynchronous reset in the middle of a stall at terminal 1
    pop = '0; pndng[1] = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    expect_now("async_reset", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    repeat (7) tick();
    expect_now("no_stale_timeout", 0, 0, 0, 0, 0, 0);
    tick();
    expect_now("fresh_timeout", 16'h0002, 0, 0, 0, 1, 0);
    pndng = '0;

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    n_lost = q.size();
    if (n_lost != 0) $display("FAIL scoreboard_drain: got %0d pending, want 0", n_lost);
    $display("%0d/%0d checks passed", n_pass, n_checks + n_lost);
    $finish;
  end

endmodule
